// File: rtl/banked_multi_read_sram_pkg.sv
// Shared state encoding and parameter-derived widths for the banked multi-read SRAM.
package banked_multi_read_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Bank index width; kept at least 1 so a single-bank build still has a legal vector.
  function automatic int calc_bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

  function automatic int calc_row_w(input int addr_w, input int num_banks);
    int w;
    w = addr_w - $clog2(num_banks);
    return (w > 0) ? w : 1;
  endfunction

  function automatic int calc_rounds_w(input int num_rd);
    return $clog2(num_rd + 1);
  endfunction

endpackage

// File: rtl/banked_multi_read_sram_bank.sv
// Single-port bank: registered read, a write in the same cycle takes priority.
module sram_bank #(
  parameter int DATA_W = 72,
  parameter int DEPTH  = 32,
  parameter int ROW_W  = 5
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ROW_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (en) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/banked_multi_read_sram.sv
// Multi-port read front end over single-port banks: per-round bank arbitration,
// same-address broadcast, write-over-read priority and a held response.
module banked_multi_read_sram
  import banked_multi_read_sram_pkg::*;
#(
  parameter int DATA_W    = 72,
  parameter int ADDR_W    = 8,
  parameter int NUM_BANKS = 8,
  parameter int NUM_RD    = 4
) (
  input  logic                           i_fire,
  input  logic                           rst,
  input  logic                           i_rd_valid,
  output logic                           o_rd_ready,
  input  logic [NUM_RD*ADDR_W-1:0]       i_rd_addr,
  input  logic [NUM_RD-1:0]              i_rd_mask,
  output logic                           o_rd_valid,
  input  logic                           i_rd_ack,
  output logic [NUM_RD*DATA_W-1:0]       o_rd_data,
  output logic [calc_rounds_w(NUM_RD)-1:0] o_rounds,
  input  logic                           i_wr_en,
  input  logic [ADDR_W-1:0]              i_wr_addr,
  input  logic [DATA_W-1:0]              i_wr_data
);

  localparam int BANK_W = calc_bank_w(NUM_BANKS);
  localparam int ROW_W  = calc_row_w(ADDR_W, NUM_BANKS);
  localparam int RND_W  = calc_rounds_w(NUM_RD);
  localparam int DEPTH  = (2**ADDR_W) / NUM_BANKS;

  state_t              state_reg, state_next;
  logic [NUM_RD-1:0]   pend_reg, pend_next;
  logic [NUM_RD-1:0]   cap_reg;
  logic [NUM_RD-1:0]   served;
  logic [RND_W-1:0]    rounds_reg;
  logic [ADDR_W-1:0]   addr_reg [NUM_RD];
  logic [DATA_W-1:0]   data_reg [NUM_RD];
  logic [BANK_W-1:0]   port_bank [NUM_RD];

  logic [NUM_BANKS-1:0] bank_grant;
  logic [ADDR_W-1:0]    bank_sel_addr [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

  logic                wr_en_q;
  logic [BANK_W-1:0]   wr_bank;
  logic [ROW_W-1:0]    wr_row;

  // Writes are suppressed while reset is held so memory survives untouched.
  assign wr_en_q = i_wr_en & ~rst;
  assign wr_bank = BANK_W'(int'(i_wr_addr) % NUM_BANKS);
  assign wr_row  = ROW_W'(int'(i_wr_addr) / NUM_BANKS);

  genvar gi;

  for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              wr_hit;

    // Lowest-index pending port mapped to this bank wins the round.
    always_comb begin
      sel_valid = 1'b0;
      sel_addr  = '0;
      for (int p = NUM_RD - 1; p >= 0; p--) begin
        if (pend_reg[p] && (port_bank[p] == BANK_W'(gi))) begin
          sel_valid = 1'b1;
          sel_addr  = addr_reg[p];
        end
      end
    end

    assign wr_hit            = wr_en_q && (wr_bank == BANK_W'(gi));
    assign bank_grant[gi]    = (state_reg == ST_ISSUE) && sel_valid && !wr_hit;
    assign bank_sel_addr[gi] = sel_addr;

    sram_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk   (i_fire),
      .en    (bank_grant[gi]),
      .we    (wr_hit),
      .addr  (wr_hit ? wr_row : ROW_W'(int'(sel_addr) / NUM_BANKS)),
      .wdata (i_wr_data),
      .rdata (bank_rdata[gi])
    );
  end

  for (gi = 0; gi < NUM_RD; gi++) begin : g_port
    assign port_bank[gi] = BANK_W'(int'(addr_reg[gi]) % NUM_BANKS);
    // Any pending port whose address matches its bank's winner rides along (broadcast).
    assign served[gi] = pend_reg[gi] && bank_grant[port_bank[gi]] &&
                        (addr_reg[gi] == bank_sel_addr[port_bank[gi]]);
    assign o_rd_data[gi*DATA_W +: DATA_W] = data_reg[gi];
  end

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_rd_valid) begin
          pend_next  = i_rd_mask;
          state_next = (|i_rd_mask) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        pend_next = pend_reg & ~served;
        if (pend_next == '0) state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_RESP;
      ST_RESP:  if (i_rd_ack) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_fire or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      pend_reg   <= '0;
      cap_reg    <= '0;
      rounds_reg <= '0;
      for (int p = 0; p < NUM_RD; p++) begin
        addr_reg[p] <= '0;
        data_reg[p] <= '0;
      end
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      cap_reg   <= (state_reg == ST_ISSUE) ? served : '0;
      if (state_reg == ST_IDLE && i_rd_valid) begin
        rounds_reg <= '0;
        for (int p = 0; p < NUM_RD; p++) begin
          addr_reg[p] <= i_rd_addr[p*ADDR_W +: ADDR_W];
          data_reg[p] <= '0;
        end
      end else begin
        // Repeated write blocking can exceed the counter range; saturate rather than wrap.
        if (state_reg == ST_ISSUE && rounds_reg != {RND_W{1'b1}})
          rounds_reg <= rounds_reg + RND_W'(1);
        for (int p = 0; p < NUM_RD; p++) begin
          if (cap_reg[p]) data_reg[p] <= bank_rdata[port_bank[p]];
        end
      end
    end
  end

  assign o_rd_ready = (state_reg == ST_IDLE);
  assign o_rd_valid = (state_reg == ST_RESP);
  assign o_rounds   = rounds_reg;

endmodule
